// File: rtl/water_level_ctrl.sv
// Tank fill controller. Debounces a thermometer-coded level sensor bank and
// ramps a committed level one step per clock, driving the fill valves from it.
module water_level_ctrl #(
    parameter int unsigned  NUM_LEVELS = 3,
    parameter int unsigned  DEBOUNCE   = 2,
    localparam int unsigned LW         = $clog2(NUM_LEVELS + 1)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_LEVELS:1] s,
    output logic [NUM_LEVELS:1] fr,
    output logic                dfr,
    output logic [LW-1:0]       level,
    output logic                fault
);

    localparam int unsigned CW     = 8;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE);

    logic [NUM_LEVELS:1] r_s_q;
    logic [CW-1:0]       r_stable_cnt;
    logic [LW-1:0]       r_level;
    logic                r_dir;
    logic                r_fault;

    logic                w_changed;
    logic                w_qual;
    logic                w_valid;
    logic [NUM_LEVELS:1] w_s_inc;
    logic [LW-1:0]       w_target;
    logic [LW-1:0]       w_level_nxt;
    logic                w_dir_nxt;
    logic                w_fault_nxt;

    assign w_changed = (s != r_s_q);
    assign w_qual    = !w_changed && (r_stable_cnt >= DB_MAX);

    // Thermometer code 0..01..1: adding one clears every set bit (all-ones wraps to zero).
    assign w_s_inc = r_s_q + NUM_LEVELS'(1);
    assign w_valid = ((r_s_q & w_s_inc) == '0);

    always_comb begin
        w_target = '0;
        for (int j = 1; j <= int'(NUM_LEVELS); j++) begin
            w_target = w_target + LW'(r_s_q[j]);
        end
    end

    // Next committed level / direction / fault on a qualified edge.
    always_comb begin
        w_level_nxt = r_level;
        w_dir_nxt   = r_dir;
        w_fault_nxt = r_fault;
        if (w_qual) begin
            if (!w_valid) begin
                w_fault_nxt = 1'b1;
            end else begin
                w_fault_nxt = 1'b0;
                if (w_target > r_level) begin
                    w_level_nxt = r_level + LW'(1);
                    w_dir_nxt   = 1'b1;
                end else if (w_target < r_level) begin
                    w_level_nxt = r_level - LW'(1);
                    w_dir_nxt   = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s_q        <= '0;
            r_stable_cnt <= '0;
            r_level      <= '0;
            r_dir        <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            if (w_changed) begin
                r_s_q        <= s;
                r_stable_cnt <= '0;
            end else if (r_stable_cnt < DB_MAX) begin
                r_stable_cnt <= r_stable_cnt + CW'(1);
            end
            r_level <= w_level_nxt;
            r_dir   <= w_dir_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // Valve j stays open while the committed level is at least j below the top.
    for (genvar j = 1; j <= int'(NUM_LEVELS); j++) begin : g_fr
        assign fr[j] = (r_level <= LW'(NUM_LEVELS - j));
    end

    assign dfr   = (r_level == '0) || ((r_level < LW'(NUM_LEVELS)) && !r_dir);
    assign level = r_level;
    assign fault = r_fault;

endmodule
